prbs_gen_chk: RTL and testbench

Parametrised PRBS generator with runtime polynomial selection, seed load and W-bit parallel output, plus a compile-time optional self-synchronising checker with lock detection and a saturating bit-error counter. It is the PRBS source and sink for link, serializer and CDR testbenches and behavioural models in the mLingua sample library. It replaces fixed single-polynomial, 1-bit-per-clock generators.

---
 rtl/prbs_pkg.sv | 106 ++++++++++
 rtl/prbs_chk.sv | 116 +++++++++++
 rtl/prbs_gen_chk.sv | 83 ++++++++
 tb/tb_prbs_gen_chk.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: polynomial table and the shared W-step PRBS kernels.
// Used by prbs_gen_chk and by the optional prbs_chk checker.
package prbs_pkg;
  localparam int MAX_ORDER = 31;

  typedef enum logic [2:0] {
    M_PRBS7  = 3'd0,
    M_PRBS9  = 3'd1,
    M_PRBS15 = 3'd2,
    M_PRBS21 = 3'd3,
    M_PRBS23 = 3'd4,
    M_PRBS31 = 3'd5
  } prbs_mode_e;

  typedef enum logic [1:0] {
    S_FILL,
    S_SEARCH,
    S_LOCKED
  } chk_state_e;

  function automatic logic [4:0] prbs_order(input logic [2:0] m);
    case (m)
      M_PRBS7:  return 5'd7;
      M_PRBS9:  return 5'd9;
      M_PRBS15: return 5'd15;
      M_PRBS21: return 5'd21;
      M_PRBS23: return 5'd23;
      default:  return 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] prbs_tap(input logic [2:0] m);
    case (m)
      M_PRBS7:  return 5'd6;
      M_PRBS9:  return 5'd5;
      M_PRBS15: return 5'd14;
      M_PRBS21: return 5'd2;
      M_PRBS23: return 5'd18;
      default:  return 5'd28;
    endcase
  endfunction

  function automatic logic [MAX_ORDER-1:0] prbs_mask(
    input logic [2:0] m
  );
    return {MAX_ORDER{1'b1}} >> (5'd31 - prbs_order(m));
  endfunction

  // Returns {next_state, out_word}; first bit lands at out[w-1].
  function automatic logic [62:0] prbs_step(
    input logic [30:0] s,
    input logic [2:0]  m,
    input int          w
  );
    logic [30:0] st;
    logic [30:0] mk;
    logic [31:0] o;
    logic [4:0]  n1;
    logic [4:0]  k1;
    logic        nb;
    st = s;
    o  = '0;
    mk = prbs_mask(m);
    n1 = prbs_order(m) - 5'd1;
    k1 = prbs_tap(m) - 5'd1;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        nb = st[n1] ^ st[k1];
        st = {st[29:0], nb} & mk;
        o  = {o[30:0], nb};
      end
    end
    return {st, o};
  endfunction

  // Self-synchronising variant: predicts, then shifts in received bits.
  function automatic logic [62:0] prbs_sync(
    input logic [30:0] s,
    input logic [2:0]  m,
    input int          w,
    input logic [31:0] din
  );
    logic [30:0] st;
    logic [30:0] mk;
    logic [31:0] mis;
    logic [31:0] d;
    logic [4:0]  n1;
    logic [4:0]  k1;
    logic        b;
    st  = s;
    mis = '0;
    d   = din << (32 - w);
    mk  = prbs_mask(m);
    n1  = prbs_order(m) - 5'd1;
    k1  = prbs_tap(m) - 5'd1;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        b   = d[31];
        d   = {d[30:0], 1'b0};
        mis = {mis[30:0], (st[n1] ^ st[k1]) ^ b};
        st  = {st[29:0], b} & mk;
      end
    end
    return {st, mis};
  endfunction
endpackage

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker with lock detection
// and a saturating bit-error counter.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int W           = 1,
  parameter int LOCK_WORDS  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_restart,
  input  logic [2:0]       i_mode,
  input  logic [W-1:0]     i_din,
  input  logic             i_vld,
  input  logic             i_clr,
  output logic             o_lock,
  output logic [ERR_W-1:0] o_err
);
  localparam int CW = $clog2(LOCK_WORDS + UNLOCK_ERRS + 34);
  localparam int SW = ERR_W + 7;

  chk_state_e       r_st, w_st;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [CW:0]      w_cnt1;
  logic [30:0]      r_c, w_c;
  logic [ERR_W-1:0] r_err;
  logic [31:0]      w_din, w_smis, w_rout, w_rmis;
  logic [30:0]      w_snext, w_rnext;
  logic [5:0]       w_pop, w_add;
  logic [SW-1:0]    w_sum;
  int               w_fill;

  assign w_din  = 32'(i_din);
  assign {w_snext, w_smis} = prbs_sync(r_c, i_mode, W, w_din);
  assign {w_rnext, w_rout} = prbs_step(r_c, i_mode, W);
  assign w_rmis = w_rout ^ w_din;
  assign w_cnt1 = {1'b0, r_cnt} + (CW+1)'(1);
  assign w_fill = (int'(prbs_order(i_mode)) + W - 1) / W;
  assign w_sum  = SW'(r_err) + SW'(w_add);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 32; i++)
      w_pop = w_pop + 6'(w_rmis[i]);
  end

  always_comb begin
    w_st  = r_st;
    w_cnt = r_cnt;
    w_c   = r_c;
    w_add = '0;
    if (i_vld) begin
      unique case (r_st)
        S_FILL: begin
          w_c = w_snext;
          if (int'(w_cnt1) >= w_fill) begin
            w_st  = S_SEARCH;
            w_cnt = '0;
          end else begin
            w_cnt = w_cnt1[CW-1:0];
          end
        end
        S_SEARCH: begin
          w_c = w_snext;
          if (w_smis != '0) begin
            w_cnt = '0;
          end else if (int'(w_cnt1) >= LOCK_WORDS) begin
            w_st  = S_LOCKED;
            w_cnt = '0;
          end else begin
            w_cnt = w_cnt1[CW-1:0];
          end
        end
        S_LOCKED: begin
          // Free-run on predictions so one bad bit counts once.
          w_c   = w_rnext;
          w_add = w_pop;
          if (w_rmis == '0) begin
            w_cnt = '0;
          end else if (int'(w_cnt1) >= UNLOCK_ERRS) begin
            w_st  = S_FILL;
            w_cnt = '0;
          end else begin
            w_cnt = w_cnt1[CW-1:0];
          end
        end
        default: w_st = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_st  <= S_FILL;
      r_cnt <= '0;
      r_c   <= '0;
    end else begin
      r_st  <= w_st;
      r_cnt <= w_cnt;
      r_c   <= w_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_err <= '0;
    else if (!i_restart && w_add != '0)
      r_err <= (w_sum > SW'({ERR_W{1'b1}})) ?
               {ERR_W{1'b1}} : w_sum[ERR_W-1:0];
  end

  assign o_lock = (r_st == S_LOCKED);
  assign o_err  = r_err;
endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: W-bit PRBS generator, runtime polynomial and seed.
// Checker built only when PRBS_CHK_EN is defined.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int W           = 1,
  parameter int LOCK_WORDS  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [30:0]      seed,
  output logic [W-1:0]     dout,
  output logic             dout_vld,
  input  logic [W-1:0]     chk_din,
  input  logic             chk_vld,
  output logic             lock,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr
);
  logic [2:0]   r_mode;
  logic [30:0]  r_state;
  logic [W-1:0] r_dout;
  logic         r_vld;
  logic [30:0]  w_mask, w_seed, w_nstate;
  logic [31:0]  w_nout;
  logic         w_unused_out;

  assign w_mask = prbs_mask(mode);
  assign w_seed = seed & w_mask;
  assign {w_nstate, w_nout} = prbs_step(r_state, r_mode, W);
  assign w_unused_out = ^(w_nout >> W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= mode;
      r_state <= w_mask;
      r_dout  <= '0;
      r_vld   <= 1'b0;
    end else if (seed_ld) begin
      r_mode  <= mode;
      r_state <= (w_seed == '0) ? w_mask : w_seed;
      r_vld   <= 1'b0;
    end else if (en) begin
      r_state <= w_nstate;
      r_dout  <= w_nout[W-1:0];
      r_vld   <= 1'b1;
    end else begin
      r_vld   <= 1'b0;
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_vld;

`ifdef PRBS_CHK_EN
  prbs_chk #(
    .W(W),
    .LOCK_WORDS(LOCK_WORDS),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .ERR_W(ERR_W)
  ) u_chk (
    .clk(clk),
    .rst(rst),
    .i_restart(seed_ld),
    .i_mode(r_mode),
    .i_din(chk_din),
    .i_vld(chk_vld),
    .i_clr(err_clr),
    .o_lock(lock),
    .o_err(err_cnt)
  );
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{chk_din, chk_vld, err_clr};
  assign lock    = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: directed checks of generator, loopback checker,
// saturation, err_clr priority and mid-stream reset.
module tb_prbs_gen_chk;
`ifdef PRBS_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst = 1'b1;
  logic [2:0]  mode_a = 3'd0, mode_b = 3'd0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        sl_a = 1'b0, sl_b = 1'b0;
  logic [30:0] seed_a = '0, seed_b = '0;
  logic [0:0]  dout_a, cdin_a = '0;
  logic [7:0]  dout_b, cdin_b = '0;
  logic        vld_a, vld_b;
  logic        cvld_a = 1'b0, cvld_b = 1'b0;
  logic        lock_a, lock_b;
  logic [15:0] err_a;
  logic [3:0]  err_b;
  logic        clr_a = 1'b0, clr_b = 1'b0;

  prbs_gen_chk #(.W(1)) u_a (
    .clk(clk), .rst(rst), .mode(mode_a), .en(en_a),
    .seed_ld(sl_a), .seed(seed_a), .dout(dout_a),
    .dout_vld(vld_a), .chk_din(cdin_a), .chk_vld(cvld_a),
    .lock(lock_a), .err_cnt(err_a), .err_clr(clr_a)
  );

  prbs_gen_chk #(.W(8), .ERR_W(4)) u_b (
    .clk(clk), .rst(rst), .mode(mode_b), .en(en_b),
    .seed_ld(sl_b), .seed(seed_b), .dout(dout_b),
    .dout_vld(vld_b), .chk_din(cdin_b), .chk_vld(cvld_b),
    .lock(lock_b), .err_cnt(err_b), .err_clr(clr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lb(input logic [7:0] flip);
    cdin_b = dout_b ^ flip;
    cvld_b = vld_b;
    tick();
  endtask

  logic       a_bits [0:133];
  logic [6:0] e7 = 7'b0000001;
  logic       q [$];
  logic [7:0] ew;
  logic       b;
  int         ones;

  initial begin
    tick();
    check("rst_dout_a", 32'(dout_a), 0);
    check("rst_vld_a", 32'(vld_a), 0);
    check("rst_dout_b", 32'(dout_b), 0);
    check("rst_lock_b", 32'(lock_b), 0);
    check("rst_err_b", 32'(err_b), 0);
    check("rst_lock_a", 32'(lock_a), 0);
    check("rst_err_a", 32'(err_a), 0);

    rst  = 1'b0;
    en_a = 1'b1;
    for (int i = 0; i < 134; i++) begin
      tick();
      a_bits[i] = dout_a[0];
      if (i == 0) check("vld_a", 32'(vld_a), 1);
    end
    for (int i = 0; i < 7; i++) begin
      check("prbs7_head", 32'(a_bits[i]), 32'(e7[6-i]));
      check("prbs7_wrap", 32'(a_bits[127+i]), 32'(e7[6-i]));
    end
    ones = 0;
    for (int i = 0; i < 127; i++) ones += int'(a_bits[i]);
    check("prbs7_ones", ones, 64);

    sl_b = 1'b1; mode_b = 3'd5; seed_b = '0; en_b = 1'b1;
    tick();
    sl_b = 1'b0;
    check("seed_vld", 32'(vld_b), 0);
    check("seed_state", 32'(u_b.r_state), 32'h7FFF_FFFF);
    for (int i = 0; i < 31; i++) q.push_back(1'b1);
    for (int w = 0; w < 1000; w++) begin
      tick();
      ew = '0;
      for (int j = 0; j < 8; j++) begin
        b = q[0] ^ q[3];
        q.push_back(b);
        void'(q.pop_front());
        ew = {ew[6:0], b};
      end
      check("prbs31_word", 32'(dout_b), 32'(ew));
      check("prbs31_vld", 32'(vld_b), 1);
      if (w == 500) mode_b = 3'd0;
    end

    cvld_b = 1'b0; sl_b = 1'b1; mode_b = 3'd2; seed_b = '0;
    tick();
    sl_b = 1'b0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      lb(8'h00);
      check("lb_lock", 32'(lock_b), 32'(CHK && k >= 10));
    end
    check("lb_err", 32'(err_b), 0);

    lb(8'h01);
    check("one_err", 32'(err_b), CHK ? 1 : 0);
    check("one_lock", 32'(lock_b), 32'(CHK));
    for (int k = 0; k < 4; k++) lb(8'h00);
    check("one_err_hold", 32'(err_b), CHK ? 1 : 0);

    for (int k = 1; k <= 4; k++) begin
      lb(8'h80);
      check("unlock", 32'(lock_b), 32'(CHK && k < 4));
    end
    check("unlock_err", 32'(err_b), CHK ? 5 : 0);
    for (int k = 1; k <= 10; k++) begin
      lb(8'h00);
      check("relock", 32'(lock_b), 32'(CHK && k >= 10));
    end

    clr_b = 1'b1;
    lb(8'h00);
    clr_b = 1'b0;
    check("clr", 32'(err_b), 0);
    for (int i = 0; i < 40; i++) begin
      lb((i % 2 == 0) ? 8'h04 : 8'h00);
      if (i == 19) check("err_mid", 32'(err_b), CHK ? 10 : 0);
    end
    check("err_sat", 32'(err_b), CHK ? 15 : 0);
    check("sat_lock", 32'(lock_b), 32'(CHK));
    clr_b = 1'b1;
    lb(8'h01);
    clr_b = 1'b0;
    check("clr_wins", 32'(err_b), 0);
    lb(8'h13);
    check("popcount", 32'(err_b), CHK ? 3 : 0);
    check("pop_lock", 32'(lock_b), 32'(CHK));

    rst = 1'b1;
    cdin_b = ~dout_b;
    cvld_b = 1'b1;
    tick();
    rst = 1'b0;
    cvld_b = 1'b0;
    check("mrst_dout_b", 32'(dout_b), 0);
    check("mrst_vld_b", 32'(vld_b), 0);
    check("mrst_lock_b", 32'(lock_b), 0);
    check("mrst_err_b", 32'(err_b), 0);
    check("mrst_dout_a", 32'(dout_a), 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("mrst_prbs7", 32'(dout_a), 32'(e7[6-i]));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
